// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-stage skid registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } pipe_state_t;

    // ARM "MOV r0, r0", the canonical decode-stage bubble.
    localparam logic [31:0] ARM_NOP = 32'hE1A00000;

endpackage

// File: rtl/pipe_stage_skid_stall_counter.sv
// Saturating up-counter with enable, used for stall-cycle statistics.
module stall_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_en && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with 2-entry skid and flush-to-NOP.
// Define PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
   ,output logic [CNT_W-1:0] stall_cnt
`endif
);

    pipe_state_t      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;

    // r_main is reloaded with NOP_VALUE whenever the stage empties,
    // so out_data needs no output mux.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main      <= NOP_VALUE;
            r_skid      <= NOP_VALUE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_main      <= NOP_VALUE;
            r_skid      <= NOP_VALUE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_state     <= ST_FULL;
                        r_main      <= in_data;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_FULL: begin
                    unique case ({w_in_xfer, w_out_xfer})
                        2'b11: r_main <= in_data;
                        2'b01: begin
                            r_state     <= ST_EMPTY;
                            r_main      <= NOP_VALUE;
                            r_out_valid <= 1'b0;
                        end
                        2'b10: begin
                            r_state    <= ST_SKID;
                            r_skid     <= in_data;
                            r_in_ready <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_SKID: begin
                    if (w_out_xfer) begin
                        r_state    <= ST_FULL;
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_main      <= NOP_VALUE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic w_stall;

    assign w_stall = r_out_valid & ~out_ready;

    stall_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_stall),
        .o_cnt (stall_cnt)
    );
`else
    int w_unused_cnt_w;

    assign w_unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector bench for pipe_stage_skid (NOP=0 and ARM NOP copies).
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;

    int n_chk;
    int n_err;

`ifdef PIPE_STALL_CNT_EN
    logic [1:0]  stall_cnt;
    logic [15:0] stall_cnt2;
`endif

    pipe_stage_skid #(
        .WIDTH     (32),
        .NOP_VALUE (32'h0),
        .CNT_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
       ,.stall_cnt (stall_cnt)
`endif
    );

    pipe_stage_skid #(
        .WIDTH     (32),
        .NOP_VALUE (ARM_NOP)
    ) dut_nop (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2)
`ifdef PIPE_STALL_CNT_EN
       ,.stall_cnt (stall_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        eov;
        logic        eir;
        logic [31:0] ed;
    } vec_t;

    localparam int NV = 25;
    vec_t tv [NV];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h",
                     nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm,
                           input logic eov,
                           input logic eir,
                           input logic [31:0] ed);
        chk({nm, ".ov"}, {31'd0, out_valid}, {31'd0, eov});
        chk({nm, ".ir"}, {31'd0, in_ready}, {31'd0, eir});
        chk({nm, ".d"}, out_data, ed);
        chk({nm, ".ov2"}, {31'd0, out_valid2}, {31'd0, eov});
        chk({nm, ".ir2"}, {31'd0, in_ready2}, {31'd0, eir});
        chk({nm, ".d2"}, out_data2, eov ? ed : ARM_NOP);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        // fl iv data ordy | ov ir data
        // streaming 1..4
        tv[0]  = '{0, 1, 32'h1,  1, 1, 1, 32'h1};
        tv[1]  = '{0, 1, 32'h2,  1, 1, 1, 32'h2};
        tv[2]  = '{0, 1, 32'h3,  1, 1, 1, 32'h3};
        tv[3]  = '{0, 1, 32'h4,  1, 1, 1, 32'h4};
        tv[4]  = '{0, 0, 32'h0,  1, 0, 1, 32'h0};
        // backpressure into skid, then drain
        tv[5]  = '{0, 1, 32'h11, 0, 1, 1, 32'h11};
        tv[6]  = '{0, 1, 32'h22, 0, 1, 0, 32'h11};
        tv[7]  = '{0, 1, 32'h99, 0, 1, 0, 32'h11};
        tv[8]  = '{0, 0, 32'h0,  1, 1, 1, 32'h22};
        tv[9]  = '{0, 0, 32'h0,  1, 0, 1, 32'h0};
        // data without valid is ignored
        tv[10] = '{0, 0, 32'h55, 0, 0, 1, 32'h0};
        // flush in skid with incoming 0x33
        tv[11] = '{0, 1, 32'h44, 0, 1, 1, 32'h44};
        tv[12] = '{0, 1, 32'h45, 0, 1, 0, 32'h44};
        tv[13] = '{1, 1, 32'h33, 0, 0, 1, 32'h0};
        tv[14] = '{0, 0, 32'h0,  1, 0, 1, 32'h0};
        // flush in full with simultaneous pop
        tv[15] = '{0, 1, 32'h66, 0, 1, 1, 32'h66};
        tv[16] = '{1, 1, 32'h77, 1, 0, 1, 32'h0};
        // full: in+out, hold, out
        tv[17] = '{0, 1, 32'h5,  0, 1, 1, 32'h5};
        tv[18] = '{0, 1, 32'h6,  1, 1, 1, 32'h6};
        tv[19] = '{0, 0, 32'h0,  0, 1, 1, 32'h6};
        tv[20] = '{0, 0, 32'h0,  1, 0, 1, 32'h0};
        // skid pop while upstream still offers (ignored)
        tv[21] = '{0, 1, 32'hA1, 0, 1, 1, 32'hA1};
        tv[22] = '{0, 1, 32'hA2, 0, 1, 0, 32'hA1};
        tv[23] = '{0, 1, 32'hA3, 1, 1, 1, 32'hA2};
        tv[24] = '{0, 0, 32'h0,  1, 0, 1, 32'h0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        #1;
        chk_all("reset", 1'b0, 1'b1, 32'h0);
        tick();
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            flush     = tv[i].fl;
            in_valid  = tv[i].iv;
            in_data   = tv[i].d;
            out_ready = tv[i].ordy;
            tick();
            chk_all($sformatf("vec%0d", i),
                    tv[i].eov, tv[i].eir, tv[i].ed);
        end

        // asynchronous reset while holding two entries
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        tick();
        in_data   = 32'hB;
        tick();
        chk_all("skid_fill", 1'b1, 1'b0, 32'hA);
        in_valid  = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("rst_skid", 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_all("rst_gone", 1'b0, 1'b1, 32'h0);

`ifdef PIPE_STALL_CNT_EN
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hC;
        tick();
        in_valid  = 1'b0;
        chk("cnt0", {30'd0, stall_cnt}, 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("cnt%0d", k), {30'd0, stall_cnt},
                (k < 3) ? k : 3);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("cnt_flush", {30'd0, stall_cnt}, 32'd3);
        chk("ov_flush", {31'd0, out_valid}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("cnt_rst", {30'd0, stall_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generalised inter-stage pipeline register for the ARM pipeline (Fetch→Decode, Decode→Execute, …), replacing fixed enable/flush registers.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stall (in_ready) is registered rather than combinationally derived from downstream.
- Flush inserts a bubble: a configurable NOP word with valid low.
- WIDTH and NOP encoding are parametrised per stage.

Parameters:
- WIDTH, 32, payload width in bits (instruction or stage bundle).
- NOP_VALUE, '0, payload driven on out_data whenever no valid entry is presented; must be WIDTH bits.
- CNT_W, 16, width of the stall-cycle counter (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  hazard-unit flush; kills all held and incoming entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  payload to next stage; NOP_VALUE when out_valid=0.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready (only with PIPE_STALL_CNT_EN).

Behaviour:
- Handshake and storage:
  - Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
  - Storage: main register (drives out_data) plus skid register.
- States and transitions:
  - EMPTY: in_ready=1, out_valid=0. In-transfer → FULL, main<=in_data.
  - FULL: in_ready=1, out_valid=1.
    - In and out together → FULL, main<=in_data.
    - Out only → EMPTY.
    - In only → SKID, skid<=in_data.
    - Neither → FULL, hold.
  - SKID: in_ready=0, out_valid=1. Out-transfer → FULL, main<=skid. Otherwise hold.
- Latency and throughput:
  - One cycle from in-transfer to out_valid when EMPTY.
  - Full throughput, 1 word/cycle, when out_ready is held high.
- Ordering: strict FIFO order; no entry duplicated or dropped except by flush.
- Flush (highest priority, takes effect at next edge):
  - State→EMPTY, out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - Any in-transfer in the flush cycle is discarded.
  - An out-transfer in the same cycle still counts as consumed downstream.
- Reset (asynchronous, any state including SKID): state=EMPTY, out_valid=0, out_data=NOP_VALUE, in_ready=1, skid=NOP_VALUE, stall_cnt=0.
- Held data: out_data must not change while out_valid=1 and out_ready=0.
- Uncaptured data: in_data is ignored when in_valid=0.
- Registered in_ready: in_ready depends only on state, never on out_ready in the same cycle.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Increments on every cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter logic absent; module otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t.
  - Localparam ARM_NOP for the decode-stage NOP encoding.
- Sub-module stall_counter (saturating counter with enable, width CNT_W): instantiated only under PIPE_STALL_CNT_EN.
- Datapath and state machine stay in pipe_stage_skid.

Test Plan:
- Reset mid-SKID (WIDTH=32, NOP_VALUE=0):
  - Stimulus: fill with 0xA, 0xB (out_ready=0), assert reset between edges.
  - Required: out_valid=0, out_data=0, in_ready=1 immediately.
- Streaming:
  - Stimulus: in_valid=1 and out_ready=1 every cycle with data 1,2,3,4.
  - Required: out_data 1,2,3,4 on consecutive cycles starting one cycle later; in_ready stays 1.
- Backpressure/skid:
  - Stimulus: push 0x11 and 0x22 with out_ready=0.
  - Required: state SKID, in_ready=0, out_data holds 0x11.
  - Then raise out_ready: 0x11, then 0x22 next cycle; in_ready=1 after the first pop.
- Flush in SKID with a simultaneous in_valid carrying 0x33:
  - Required next cycle: out_valid=0, out_data=NOP_VALUE, in_ready=1.
  - 0x33 never appears on out_data.
- NOP_VALUE=32'hE1A00000:
  - After reset and after flush, out_data=E1A00000 with out_valid=0.
- PIPE_STALL_CNT_EN with CNT_W=2:
  - Stimulus: hold valid output with out_ready=0 for 6 cycles.
  - Required: stall_cnt 1,2,3,3,3,3.
  - Flush leaves it at 3; reset clears it to 0.
